// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory arbiter and its tag pipe.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default bus widths, read-owner encoding, and the in-flight read
// tag carried alongside each RAM access until its data returns.
package cpu_mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Owner of an in-flight read: which port the returning word belongs to.
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // One pipe stage: a read is outstanding (vld), who issued it (own), and
  // whether a fetch flush has since cancelled it (kill).
  typedef struct packed {
    logic vld;
    logic own;
    logic kill;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/arb_tag_pipe.sv
// Owner tag shift register that tracks reads in flight through the RAM.
// Latency: DEPTH cycles from load to output, one stage per cycle, no stalls.
// Backpressure: none; a new tag (possibly invalid) enters every cycle.
// Ports: clk/rst (async active-high); in_vld/in_own = tag entering stage 0;
// flush = kill every I-owned tag, including the one entering and the one
// leaving this cycle; out_vld/out_own = live (unkilled) tag at the last stage.
module arb_tag_pipe
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_vld,
  input  logic in_own,
  input  logic flush,
  output logic out_vld,
  output logic out_own
);

  tag_t tag_q [DEPTH];
  tag_t tag_d [DEPTH];
  tag_t tail;

  always_comb begin
    tag_d[0].vld  = in_vld;
    tag_d[0].own  = in_own;
    tag_d[0].kill = flush && (in_own == OWN_I);
    for (int s = 1; s < DEPTH; s++) begin
      tag_d[s] = tag_q[s-1];
      if (flush && (tag_q[s-1].own == OWN_I)) begin
        tag_d[s].kill = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        tag_q[s] <= tag_d[s];
      end
    end
  end

  // The tag leaving this cycle is still in flight, so a same-cycle flush
  // must cancel it too; its rvalid would otherwise appear after the flush.
  assign tail    = tag_q[DEPTH-1];
  assign out_vld = tail.vld && !tail.kill && !(flush && (tail.own == OWN_I));
  assign out_own = tail.own;

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one single-port sync RAM between fetch (I) and load/store (D), D first.
// Latency: grant is combinational; read data rvalid arrives MEM_LAT+1 cycles after grant.
// Backpressure: a request waits (req held) until its grant; one access per cycle.
// Ports: clk, rst (async active-high); I port i_req/i_addr/i_flush -> i_gnt,
// i_rvalid, i_rdata; D port d_req/d_we/d_addr/d_wdata -> d_gnt, d_rvalid,
// d_rdata; RAM side mem_en/mem_we/mem_addr (word address)/mem_wdata, mem_rdata.
// Build option ARB_FETCH_GUARD_EN: after STARVE_LIMIT D grants with I waiting,
// I is granted once over D.
module cpu_mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if ((MEM_LAT < 1) || (MEM_LAT > 3)) begin : g_bad_lat
    $error("cpu_mem_arbiter: MEM_LAT must be in 1..3");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("cpu_mem_arbiter: STARVE_LIMIT must be at least 1");
  end

  logic fetch_force;

`ifdef ARB_FETCH_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_q, starve_d;

  // Counts D grants that went past a waiting fetch; saturates at the limit.
  always_comb begin
    starve_d = starve_q;
    if (!i_req || i_gnt) begin
      starve_d = '0;
    end else if (d_gnt && (starve_q != CNT_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

  assign fetch_force = i_req && (starve_q == CNT_W'(STARVE_LIMIT));
`else
  assign fetch_force = 1'b0;
`endif

  // Grants are suppressed for the whole reset so the RAM sees no access.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (fetch_force)  i_gnt = 1'b1;
      else if (d_req)   d_gnt = 1'b1;
      else if (i_req)   i_gnt = 1'b1;
    end
  end

  assign mem_en = i_gnt | d_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr >> 2;
      mem_wdata = d_wdata;
    end else if (i_gnt) begin
      mem_addr  = i_addr >> 2;
    end
  end

  logic rd_vld, rd_own;

  arb_tag_pipe #(.DEPTH(MEM_LAT)) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  ((d_gnt && !d_we) || i_gnt),
    .in_own  (d_gnt ? OWN_D : OWN_I),
    .flush   (i_flush),
    .out_vld (rd_vld),
    .out_own (rd_own)
  );

  logic              i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

  // The tag at the pipe tail lines up with mem_rdata; capture for its owner.
  always_comb begin
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    if (rd_vld) begin
      if (rd_own == OWN_I) begin
        i_rvalid_d = 1'b1;
        i_rdata_d  = mem_rdata;
      end else begin
        d_rvalid_d = 1'b1;
        d_rdata_d  = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign i_rvalid = i_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: directed scenarios plus a randomized phase.
// A reference model predicts grants and read returns into queues; a monitor
// on the falling edge compares the DUT against those expectations.
module tb_cpu_mem_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LAT   = 2;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0, i_flush = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  cpu_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Write-first synchronous RAM with LAT-cycle read latency.
  logic [DW-1:0] ram     [256];
  logic [DW-1:0] rd_pipe [LAT];
  logic [DW-1:0] shadow  [256];

  function automatic logic [DW-1:0] init_word(input int w);
    return 32'h5A00_0000 ^ (w * 32'h0001_0203);
  endfunction

  initial begin
    for (int w = 0; w < 256; w++) begin
      ram[w]    = init_word(w);
      shadow[w] = init_word(w);
    end
    for (int k = 0; k < LAT; k++) rd_pipe[k] = '0;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      rd_pipe[0] <= mem_we ? mem_wdata : ram[mem_addr[7:0]];
    end
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // Reference model state.
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } ret_t;

  ret_t          qi[$], qd[$];
  logic [DW-1:0] hold_i = '0, hold_d = '0;
  int            starve = 0;
  int            cyc = 0;
  int            n_vec = 0, n_bad = 0;
  logic          i_gnt_s = 1'b0, d_gnt_s = 1'b0;
  logic          exp_ig, exp_dg, exp_iv, exp_dv;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("gnt_in_reset", {i_gnt, d_gnt, mem_en}, 3'b000);
      chk("rvalid_in_reset", {i_rvalid, d_rvalid}, 2'b00);
      qi.delete();
      qd.delete();
      hold_i = '0;
      hold_d = '0;
      starve = 0;
      chk("i_rdata_reset", i_rdata, 0);
      chk("d_rdata_reset", d_rdata, 0);
    end else begin
      // Read returns due in this cycle.
      exp_iv = (qi.size() > 0) && (qi[0].due == cyc);
      exp_dv = (qd.size() > 0) && (qd[0].due == cyc);
      chk("i_rvalid", i_rvalid, exp_iv);
      chk("d_rvalid", d_rvalid, exp_dv);
      if (exp_iv) begin hold_i = qi[0].data; void'(qi.pop_front()); end
      if (exp_dv) begin hold_d = qd[0].data; void'(qd.pop_front()); end
      chk("i_rdata", i_rdata, hold_i);
      chk("d_rdata", d_rdata, hold_d);

      // Arbitration: D wins unless the fetch guard has run out of patience.
      exp_dg = d_req;
      exp_ig = i_req && !d_req;
`ifdef ARB_FETCH_GUARD_EN
      if (i_req && (starve == LIMIT)) begin
        exp_ig = 1'b1;
        exp_dg = 1'b0;
      end
`endif
      chk("i_gnt", i_gnt, exp_ig);
      chk("d_gnt", d_gnt, exp_dg);
      chk("mem_en", mem_en, exp_ig | exp_dg);
      if (exp_dg) begin
        chk("mem_addr_d", mem_addr, d_addr / 4);
        chk("mem_we_d", mem_we, d_we);
        if (d_we) chk("mem_wdata", mem_wdata, d_wdata);
      end else if (exp_ig) begin
        chk("mem_addr_i", mem_addr, i_addr / 4);
        chk("mem_we_i", mem_we, 0);
      end else begin
        chk("mem_idle", {mem_we, mem_addr}, 0);
      end

      // A flush discards every fetch not yet returned, including this cycle's.
      if (i_flush) qi.delete();
      if (exp_dg) begin
        if (d_we) shadow[d_addr[9:2]] = d_wdata;
        else qd.push_back('{cyc + LAT + 1, shadow[d_addr[9:2]]});
      end
      if (exp_ig && !i_flush) qi.push_back('{cyc + LAT + 1, shadow[i_addr[9:2]]});
`ifdef ARB_FETCH_GUARD_EN
      if (!i_req || exp_ig) starve = 0;
      else if (exp_dg && (starve < LIMIT)) starve++;
`endif
    end
    i_gnt_s = i_gnt;
    d_gnt_s = d_gnt;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with a pending fetch, then the fetch from 0x100 proceeds.
    rst = 1'b1; i_req = 1'b1; i_addr = 32'h100;
    repeat (3) tick();
    rst = 1'b0;
    tick(); i_req = 1'b0;
    repeat (LAT + 2) tick();

    // Simultaneous requests: D first, I next cycle.
    i_req = 1'b1; i_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    tick(); d_req = 1'b0;
    tick(); i_req = 1'b0;
    repeat (LAT + 2) tick();

    // Store then load to the same address on consecutive cycles.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
    tick(); d_we = 1'b0;
    tick(); d_req = 1'b0;
    repeat (LAT + 2) tick();

    // Three back-to-back fetches, flush on the third, then a fresh fetch.
    i_req = 1'b1; i_addr = 32'h0;
    tick(); i_addr = 32'h4;
    tick(); i_addr = 32'h8; i_flush = 1'b1;
    tick(); i_flush = 1'b0; i_addr = 32'h200;
    tick(); i_req = 1'b0;
    repeat (LAT + 2) tick();

    // Continuous D loads against a waiting fetch.
    i_req = 1'b1; i_addr = 32'h300;
    for (int n = 0; n < 10; n++) begin
      if (n == 0 || d_gnt_s) begin
        d_req  = 1'b1; d_we = 1'b0;
        d_addr = {22'b0, 8'($urandom), 2'b00};
      end
      tick();
    end
    d_req = 1'b0;
    tick(); i_req = 1'b0;
    repeat (LAT + 2) tick();

    // Randomized traffic on a small address window.
    for (int n = 0; n < 600; n++) begin
      if (!i_req || i_gnt_s) begin
        i_req  = ($urandom % 3) != 0;
        i_addr = {26'b0, 4'($urandom), 2'b00};
      end
      if (!d_req || d_gnt_s) begin
        d_req   = ($urandom % 2) != 0;
        d_we    = ($urandom % 2) != 0;
        d_addr  = {26'b0, 4'($urandom), 2'b00};
        d_wdata = $urandom;
      end
      i_flush = ($urandom % 8) == 0;
      tick();
    end
    i_req = 1'b0; d_req = 1'b0; i_flush = 1'b0;
    repeat (LAT + 2) tick();

    // Reset one cycle after a D read grant: the return must vanish.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h84;
    tick(); d_req = 1'b0; rst = 1'b1;
    tick();
    tick(); rst = 1'b0;
    repeat (LAT + 4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
